// File: rtl/core_pkg.sv
// Types and constants shared by the pipeline stages.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} pairs, with a flush that
// empties it in one cycle (used on redirects).
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so masking the incremented pointer wraps it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr + AW'(1)) & PTR_MASK;
      if (do_pop)  rd_ptr <= (rd_ptr + AW'(1)) & PTR_MASK;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC owner, credit-limited in-order fetch from
// instruction memory, response buffering and the IF/ID pipeline register.
module stage_if
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        ctrl_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credits_used;
  logic            fifo_empty;
  logic            req_fire;
  logic            rsp_accept;
  logic            bypass;
  logic            fifo_push;
  logic            fifo_pop;
  fetch_entry_t    rsp_entry;
  fetch_entry_t    fifo_head;

  // Outstanding plus buffered words may never exceed the FIFO depth, which
  // is what guarantees every accepted response has somewhere to go.
  assign credits_used   = {1'b0, inflight} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !br_taken && (credits_used < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_accept = imem_rsp_valid && (drop_cnt == '0) && !br_taken;
  assign bypass     = rsp_accept && fifo_empty && !ctrl_stall;
  assign fifo_push  = rsp_accept && !bypass;
  assign fifo_pop   = !br_taken && !ctrl_stall && !fifo_empty;
  assign rsp_entry  = '{pc: rsp_pc_q, inst: imem_rsp_data};

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (br_taken),
    .push      (fifo_push),
    .push_data (rsp_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
    end else if (br_taken) begin
      pc_q     <= br_target;
      rsp_pc_q <= br_target;
    end else begin
      if (req_fire)   pc_q     <= pc_q + 32'd4;
      if (rsp_accept) rsp_pc_q <= rsp_pc_q + 32'd4;
    end
  end

  // Every response retires one in-flight request, whether kept or dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      case ({req_fire, imem_rsp_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (br_taken)
        drop_cnt <= inflight - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
      if_pc    <= RESET_PC;
    end else if (br_taken) begin
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
    end else if (!ctrl_stall) begin
      if (!fifo_empty) begin
        if_valid <= 1'b1;
        if_inst  <= fifo_head.inst;
        if_pc    <= fifo_head.pc;
      end else if (bypass) begin
        if_valid <= 1'b1;
        if_inst  <= imem_rsp_data;
        if_pc    <= rsp_pc_q;
      end else begin
        if_valid <= 1'b0;
        if_inst  <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Randomized bench for stage_if: a queued memory model plus an expected
// instruction-stream model (next PC after each redirect/reset).
module tb_stage_if;
  import core_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] SCRAMBLE = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ctrl_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  stage_if #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ctrl_stall     (ctrl_stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    memq[$];
  mem_req_t    new_req;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          delivered = 0;
  int          p_stall = 0, p_ready = 100, p_br = 0, min_lat = 1, max_lat = 1;
  logic [31:0] exp_pc, exp_req;
  logic        s_req_valid, s_hs, s_rsp, s_br, s_stall, s_rst;
  logic [31:0] s_addr, s_tgt;
  logic        pv;
  logic [31:0] pi, pp;
  logic        found;
  int          mark;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic draw_inputs();
    ctrl_stall     = ($urandom_range(99) < p_stall);
    imem_req_ready = ($urandom_range(99) < p_ready);
    br_taken       = ($urandom_range(99) < p_br);
    br_target      = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].addr ^ SCRAMBLE;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
  endtask

  // One clock: observe the cycle's handshakes, advance memory and stream
  // models across the edge, check IF/ID, then choose the next inputs.
  task automatic tick();
    int lat;
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_hs        = imem_req_valid && imem_req_ready;
    s_addr      = imem_req_addr;
    s_rsp       = imem_rsp_valid;
    s_br        = br_taken;
    s_tgt       = br_target;
    s_stall     = ctrl_stall;
    s_rst       = rst;
    pv = if_valid;
    pi = if_inst;
    pp = if_pc;
    if (s_rst || s_br) chk("req_blocked", 32'(s_req_valid), 32'd0);
    if (s_hs) chk("req_addr", s_addr, exp_req);
    @(posedge clk);
    #1;
    if (s_rst) begin
      memq.delete();
      last_due = 0;
      exp_req  = RESET_PC;
    end else begin
      if (s_rsp && memq.size() > 0) void'(memq.pop_front());
      if (s_br) exp_req = s_tgt;
      else if (s_hs) exp_req = exp_req + 32'd4;
      if (s_hs) begin
        lat = $urandom_range(max_lat, min_lat);
        new_req.addr = s_addr;
        new_req.due  = (cyc + lat < last_due) ? last_due : cyc + lat;
        last_due     = new_req.due;
        memq.push_back(new_req);
      end
    end
    chk("outstanding_cap", 32'(memq.size() <= DEPTH), 32'd1);
    if (!if_valid) chk("nop_when_idle", if_inst, NOP_INST);
    if (s_rst) begin
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_pc", if_pc, RESET_PC);
      exp_pc = RESET_PC;
    end else if (s_br) begin
      chk("br_valid", 32'(if_valid), 32'd0);
      exp_pc = s_tgt;
    end else if (s_stall) begin
      chk("hold_valid", 32'(if_valid), 32'(pv));
      chk("hold_inst", if_inst, pi);
      chk("hold_pc", if_pc, pp);
    end else if (if_valid) begin
      chk("stream_pc", if_pc, exp_pc);
      chk("stream_inst", if_inst, exp_pc ^ SCRAMBLE);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    cyc++;
    draw_inputs();
  endtask

  task automatic wait_valid(input int budget, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (if_valid) hit = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    ctrl_stall = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'd0;
    exp_pc  = RESET_PC;
    exp_req = RESET_PC;
    repeat (3) tick();
    chk("reset_inst", if_inst, NOP_INST);

    // Release: request in the first cycle, valid two edges later, then 1/cycle.
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    tick();
    chk("first_valid_early", 32'(if_valid), 32'd0);
    tick();
    chk("first_valid", 32'(if_valid), 32'd1);
    chk("first_pc", if_pc, RESET_PC);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sustained_valid", 32'(if_valid), 32'd1);
    end

    // Stall: credits run out and the request line drops.
    ctrl_stall = 1'b1;
    p_stall = 100;
    repeat (5) tick();
    #1;
    chk("credit_cap_req_low", 32'(imem_req_valid), 32'd0);
    ctrl_stall = 1'b0;
    p_stall = 0;
    repeat (8) tick();

    // Ready toggling with 3-cycle memory.
    p_ready = 50; min_lat = 3; max_lat = 3;
    repeat (60) tick();

    // Redirect to 0x100 with two requests in flight.
    p_ready = 100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (memq.size() == 2) found = 1'b1;
    end
    chk("two_inflight_reached", 32'(found), 32'd1);
    br_taken = 1'b1; br_target = 32'h100;
    tick();
    chk("br100_flush", 32'(if_valid), 32'd0);
    wait_valid(40, found);
    chk("br100_seen", 32'(found), 32'd1);
    chk("br100_pc", if_pc, 32'h100);

    // Redirect, stall and a response all in one cycle.
    min_lat = 1; max_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_rsp_valid) found = 1'b1;
    end
    chk("rsp_for_br_stall", 32'(found), 32'd1);
    br_taken = 1'b1; br_target = 32'h200; ctrl_stall = 1'b1;
    tick();
    wait_valid(40, found);
    chk("br200_seen", 32'(found), 32'd1);
    chk("br200_pc", if_pc, 32'h200);

    // Redirect latency with 1-cycle memory.
    repeat (6) tick();
    br_taken = 1'b1; br_target = 32'h300;
    tick();
    chk("br300_r1_valid", 32'(if_valid), 32'd0);
    #1;
    chk("br300_r1_req", 32'(imem_req_valid), 32'd1);
    chk("br300_r1_addr", imem_req_addr, 32'h300);
    tick();
    chk("br300_r2_valid", 32'(if_valid), 32'd0);
    tick();
    chk("br300_r3_valid", 32'(if_valid), 32'd1);
    chk("br300_r3_pc", if_pc, 32'h300);

    // Reset mid-stream with the FIFO filled under stall.
    ctrl_stall = 1'b1;
    p_stall = 100;
    repeat (5) tick();
    p_stall = 0;
    ctrl_stall = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_inst", if_inst, NOP_INST);
    rst = 1'b0;
    #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("midrst_req_addr", imem_req_addr, RESET_PC);
    wait_valid(10, found);
    chk("midrst_restart", 32'(found), 32'd1);
    chk("midrst_pc", if_pc, RESET_PC);

    // Random traffic: stalls, ready gaps, variable latency, redirects.
    p_stall = 25; p_ready = 70; min_lat = 1; max_lat = 4; p_br = 3;
    repeat (1500) tick();

    p_stall = 0; p_ready = 100; min_lat = 1; max_lat = 1; p_br = 0;
    ctrl_stall = 1'b0; br_taken = 1'b0;
    mark = delivered;
    repeat (30) tick();
    chk("drain_progress", 32'(delivered - mark >= 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
